// File: rtl/sd_cmd_issue_ctrl_if.sv
// Purpose: bundles the command-side and serial-host-side signals of the SD command issue controller.
// Latency: none, wiring only.
// Backpressure: carries the REQ/ACK handshakes; no buffering of its own.
interface sd_cmd_issue_ctrl_if;
  // Register/host command side
  logic        start_i;
  logic [5:0]  cmd_index_i;
  logic [31:0] cmd_arg_i;
  logic [1:0]  resp_type_i;
  logic [2:0]  dly_i;
  logic        block_write_i;
  logic        block_read_i;
  logic [1:0]  bus_width_i;
  logic        idx_chk_en_i;
  logic        crc_chk_en_i;
  logic [15:0] timeout_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] resp_o;
  logic [3:0]  err_o;

  // Serial host side
  logic [15:0] SETTING_OUT;
  logic [39:0] CMD_OUT;
  logic        REQ_OUT;
  logic        ACK_OUT;
  logic        ser_req_i;
  logic        ser_ack_i;
  logic [39:0] ser_cmd_i;
  logic [15:0] ser_status_i;

  // Drives the controller: the host plus the serial host model
  modport master (
    output start_i, cmd_index_i, cmd_arg_i, resp_type_i, dly_i, block_write_i,
           block_read_i, bus_width_i, idx_chk_en_i, crc_chk_en_i, timeout_i,
           ser_req_i, ser_ack_i, ser_cmd_i, ser_status_i,
    input  busy_o, done_o, resp_o, err_o, SETTING_OUT, CMD_OUT, REQ_OUT, ACK_OUT
  );

  // The controller itself
  modport slave (
    input  start_i, cmd_index_i, cmd_arg_i, resp_type_i, dly_i, block_write_i,
           block_read_i, bus_width_i, idx_chk_en_i, crc_chk_en_i, timeout_i,
           ser_req_i, ser_ack_i, ser_cmd_i, ser_status_i,
    output busy_o, done_o, resp_o, err_o, SETTING_OUT, CMD_OUT, REQ_OUT, ACK_OUT
  );
endinterface

// File: rtl/sd_cmd_issue_ctrl.sv
// Purpose: issues one SD command to the serial host, collects the response, flags errors/timeouts.
// Latency: all outputs registered; REQ_OUT one edge after start_i, done_o one edge after ser_req_i drops.
// Backpressure: start_i only accepted in IDLE; issue and completion legs wait on ser_ack_i / ser_req_i.
module sd_cmd_issue_ctrl (
  input logic                SD_CLK_IN,
  input logic                RST_IN,
  sd_cmd_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_ACK  = 2'd3
  } state_t;

  // Response-length field values for the serial host SETTING word
  localparam logic [6:0] LEN_NONE  = 7'd0;
  localparam logic [6:0] LEN_SHORT = 7'd40;
  localparam logic [6:0] LEN_LONG  = 7'd127;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [39:0] cmd_q, cmd_d;
  logic [15:0] set_q, set_d;
  logic        req_q, req_d;
  logic        ack_q, ack_d;
  logic        done_q, done_d;
  logic [31:0] resp_q, resp_d;
  logic [3:0]  err_q, err_d;

  // Command fields needed after issue, latched at start
  logic [5:0]  idx_q, idx_d;
  logic [1:0]  rtype_q, rtype_d;
  logic        idx_en_q, idx_en_d;
  logic        crc_en_q, crc_en_d;
  logic [15:0] tmo_q, tmo_d;

  logic [6:0]  len_sel;
  logic        short_rsp;
  logic        frm_err;
  logic        idx_err;
  logic        crc_err;
  logic        tmo_hit;
  logic        unused_status;

  // Only the CRC-valid status bit is meaningful to this block
  assign unused_status = ^{bus.ser_status_i[15:7], bus.ser_status_i[5:0]};

  // Response length encoding from the live request (reserved type behaves as short)
  always_comb begin
    len_sel = LEN_SHORT;
    case (bus.resp_type_i)
      2'b00:   len_sel = LEN_NONE;
      2'b10:   len_sel = LEN_LONG;
      default: len_sel = LEN_SHORT;
    endcase
  end

  // Error checks only apply to short (and reserved) responses
  assign short_rsp = (rtype_q == 2'b01) || (rtype_q == 2'b11);
  assign frm_err   = (bus.ser_cmd_i[39:38] != 2'b00);
  assign idx_err   = idx_en_q && (bus.ser_cmd_i[37:32] != idx_q);
  assign crc_err   = crc_en_q && !bus.ser_status_i[6];
  assign tmo_hit   = (tmo_q != 16'd0) && (cnt_q == tmo_q);

  // State and output register bank
  always_ff @(posedge SD_CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cmd_q    <= '0;
      set_q    <= '0;
      req_q    <= 1'b0;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      resp_q   <= '0;
      err_q    <= '0;
      idx_q    <= '0;
      rtype_q  <= '0;
      idx_en_q <= 1'b0;
      crc_en_q <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      set_q    <= set_d;
      req_q    <= req_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      resp_q   <= resp_d;
      err_q    <= err_d;
      idx_q    <= idx_d;
      rtype_q  <= rtype_d;
      idx_en_q <= idx_en_d;
      crc_en_q <= crc_en_d;
      tmo_q    <= tmo_d;
    end
  end

  // Next-state and next-output logic; everything holds unless a transition changes it
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cmd_d    = cmd_q;
    set_d    = set_q;
    req_d    = req_q;
    ack_d    = ack_q;
    done_d   = 1'b0;
    resp_d   = resp_q;
    err_d    = err_q;
    idx_d    = idx_q;
    rtype_d  = rtype_q;
    idx_en_d = idx_en_q;
    crc_en_d = crc_en_q;
    tmo_d    = tmo_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          idx_d    = bus.cmd_index_i;
          rtype_d  = bus.resp_type_i;
          idx_en_d = bus.idx_chk_en_i;
          crc_en_d = bus.crc_chk_en_i;
          tmo_d    = bus.timeout_i;
          resp_d   = '0;
          err_d    = '0;
          cmd_d    = {2'b01, bus.cmd_index_i, bus.cmd_arg_i};
          set_d    = {1'b0, bus.bus_width_i, bus.block_read_i, bus.block_write_i,
                      bus.dly_i, 1'b0, len_sel};
          req_d    = 1'b1;
          state_d  = ST_REQ;
        end
      end

      ST_REQ: begin
        // No timeout here: the serial host always accepts eventually
        if (bus.ser_ack_i) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
        // A response arriving on the timeout edge takes priority
        if (bus.ser_req_i) begin
          resp_d  = bus.ser_cmd_i[31:0];
          err_d   = short_rsp ? {1'b0, crc_err, idx_err, frm_err} : 4'b0000;
          ack_d   = 1'b1;
          state_d = ST_ACK;
        end else if (tmo_hit) begin
          err_d   = 4'b1000;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_ACK: begin
        if (!bus.ser_req_i) begin
          ack_d   = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.busy_o      = (state_q != ST_IDLE);
  assign bus.done_o      = done_q;
  assign bus.resp_o      = resp_q;
  assign bus.err_o       = err_q;
  assign bus.SETTING_OUT = set_q;
  assign bus.CMD_OUT     = cmd_q;
  assign bus.REQ_OUT     = req_q;
  assign bus.ACK_OUT     = ack_q;

endmodule

// File: tb/tb_sd_cmd_issue_ctrl.sv
// Purpose: directed plus randomized checks of sd_cmd_issue_ctrl against a transaction-level model.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: bench plays the serial host, varying ack and response delays.
module tb_sd_cmd_issue_ctrl;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  sd_cmd_issue_ctrl_if bus ();

  sd_cmd_issue_ctrl dut (
    .SD_CLK_IN (clk),
    .RST_IN    (rst_n),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case anything ever stalls
  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: command word is start bits 01, then index, then argument
  function automatic logic [39:0] model_cmd(input logic [5:0] idx, input logic [31:0] arg);
    return (40'd1 << 38) + (40'(idx) << 32) + 40'(arg);
  endfunction

  // Model: SETTING word built from field weights
  function automatic logic [15:0] model_set(input logic [1:0] rt, input logic [2:0] dly,
                                            input logic bwr, input logic brd, input logic [1:0] bw);
    int len;
    len = (rt == 2'd0) ? 0 : (rt == 2'd2) ? 127 : 40;
    return 16'(len + int'(dly) * 256 + int'(bwr) * 2048 + int'(brd) * 4096 + int'(bw) * 8192);
  endfunction

  // Model: error flags for a completed response
  function automatic logic [3:0] model_err(input logic [1:0] rt, input logic [5:0] idx,
                                           input logic ien, input logic cen,
                                           input logic [39:0] rcmd, input logic [15:0] st);
    logic [3:0] e;
    e = 4'd0;
    if (rt == 2'd1 || rt == 2'd3) begin
      if (rcmd[39:38] != 2'd0)               e[0] = 1'b1;
      if (ien && (rcmd[37:32] != idx))       e[1] = 1'b1;
      if (cen && !st[6])                     e[2] = 1'b1;
    end
    return e;
  endfunction

  // One full command; rsp_dly<0 means the serial host never answers
  task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [1:0] rt, input logic [2:0] dly, input logic bwr,
                         input logic brd, input logic [1:0] bw, input logic ien, input logic cen,
                         input logic [15:0] tmo, input int ack_dly, input int rsp_dly,
                         input int hold, input logic [39:0] rcmd, input logic [15:0] rst_v,
                         input logic poke);
    logic [39:0] ecmd;
    logic [15:0] eset;
    logic        timed_out;
    logic        saw_done;
    ecmd = model_cmd(idx, arg);
    eset = model_set(rt, dly, bwr, brd, bw);
    timed_out = (tmo != 16'd0) && ((rsp_dly < 0) || (int'(tmo) < rsp_dly));
    saw_done = 1'b0;

    bus.start_i = 1'b1;
    bus.cmd_index_i = idx; bus.cmd_arg_i = arg; bus.resp_type_i = rt; bus.dly_i = dly;
    bus.block_write_i = bwr; bus.block_read_i = brd; bus.bus_width_i = bw;
    bus.idx_chk_en_i = ien; bus.crc_chk_en_i = cen; bus.timeout_i = tmo;
    step();
    bus.start_i = 1'b0;
    // Scramble live inputs: the controller must work from latched copies
    bus.cmd_index_i = 6'($urandom); bus.cmd_arg_i = $urandom; bus.resp_type_i = 2'($urandom);
    bus.idx_chk_en_i = 1'($urandom); bus.crc_chk_en_i = 1'($urandom);
    bus.timeout_i = 16'($urandom);
    chk({tag, " issue busy"}, 64'(bus.busy_o), 64'd1);
    chk({tag, " issue req"}, 64'(bus.REQ_OUT), 64'd1);
    chk({tag, " issue cmd"}, 64'(bus.CMD_OUT), 64'(ecmd));
    chk({tag, " issue setting"}, 64'(bus.SETTING_OUT), 64'(eset));
    chk({tag, " issue clr"}, {28'd0, bus.err_o, bus.resp_o}, 64'd0);

    repeat (ack_dly) step();
    chk({tag, " req held"}, {bus.REQ_OUT, bus.CMD_OUT, bus.SETTING_OUT}, {1'b1, ecmd, eset});
    bus.ser_ack_i = 1'b1;
    step();
    bus.ser_ack_i = 1'b0;
    chk({tag, " req fall"}, {bus.REQ_OUT, bus.busy_o}, {1'b0, 1'b1});

    if (timed_out) begin
      repeat (int'(tmo)) begin
        step();
        saw_done |= bus.done_o;
      end
      chk({tag, " no early tmo"}, 64'(saw_done), 64'd0);
      step();
      chk({tag, " tmo done"}, 64'(bus.done_o), 64'd1);
      chk({tag, " tmo err/resp"}, {28'd0, bus.err_o, bus.resp_o}, {28'd0, 4'b1000, 32'd0});
      chk({tag, " tmo idle"}, {bus.busy_o, bus.REQ_OUT, bus.ACK_OUT}, 3'b000);
      step();
      chk({tag, " tmo pulse"}, 64'(bus.done_o), 64'd0);
    end else begin
      for (int i = 0; i < rsp_dly; i++) begin
        if (poke && i == 0) begin
          bus.start_i = 1'b1;
          bus.cmd_index_i = ~idx;
          bus.cmd_arg_i = ~arg;
        end
        step();
        bus.start_i = 1'b0;
        saw_done |= bus.done_o;
      end
      chk({tag, " wait quiet"}, {bus.busy_o, saw_done, bus.CMD_OUT}, {1'b1, 1'b0, ecmd});
      bus.ser_req_i = 1'b1;
      bus.ser_cmd_i = rcmd;
      bus.ser_status_i = rst_v;
      step();
      chk({tag, " ack rise"}, {bus.ACK_OUT, bus.done_o}, 2'b10);
      chk({tag, " resp"}, 64'(bus.resp_o), 64'(rcmd[31:0]));
      chk({tag, " err"}, 64'(bus.err_o), 64'(model_err(rt, idx, ien, cen, rcmd, rst_v)));
      bus.ser_cmd_i = {8'($urandom), $urandom};
      bus.ser_status_i = 16'($urandom);
      repeat (hold) step();
      chk({tag, " ack held"}, {bus.ACK_OUT, bus.done_o, bus.busy_o}, 3'b101);
      bus.ser_req_i = 1'b0;
      step();
      chk({tag, " done"}, {bus.ACK_OUT, bus.done_o, bus.busy_o}, 3'b010);
      chk({tag, " resp hold"}, {28'd0, bus.err_o, bus.resp_o},
          {28'd0, model_err(rt, idx, ien, cen, rcmd, rst_v), rcmd[31:0]});
      step();
      chk({tag, " done pulse"}, 64'(bus.done_o), 64'd0);
    end
  endtask

  initial begin
    logic [5:0]  r_idx;
    logic [1:0]  r_rt;
    logic [15:0] r_tmo;
    logic [39:0] r_cmd;
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    bus.start_i = 1'b0; bus.cmd_index_i = '0; bus.cmd_arg_i = '0; bus.resp_type_i = '0;
    bus.dly_i = '0; bus.block_write_i = 1'b0; bus.block_read_i = 1'b0; bus.bus_width_i = '0;
    bus.idx_chk_en_i = 1'b0; bus.crc_chk_en_i = 1'b0; bus.timeout_i = '0;
    bus.ser_req_i = 1'b0; bus.ser_ack_i = 1'b0; bus.ser_cmd_i = '0; bus.ser_status_i = '0;
    step();
    step();
    chk("reset outputs",
        {bus.busy_o, bus.done_o, bus.REQ_OUT, bus.ACK_OUT, bus.err_o, bus.resp_o},
        64'd0);
    chk("reset cmd/setting", {bus.CMD_OUT, bus.SETTING_OUT}, 64'd0);
    rst_n = 1'b1;
    step();
    chk("post reset idle", {bus.busy_o, bus.REQ_OUT}, 2'b00);

    // Short CMD17 read, checked also against literal serial-host words
    run_cmd("cmd17", 6'd17, 32'h0000_1000, 2'b01, 3'd3, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1,
            16'd0, 4, 2, 2, 40'h11_0000_0900, 16'h0040, 1'b0);
    chk("cmd17 literal cmd", 64'(bus.CMD_OUT), 64'h51_0000_1000);
    chk("cmd17 literal setting", 64'(bus.SETTING_OUT), 64'h4328);
    chk("cmd17 literal resp/err", {28'd0, bus.err_o, bus.resp_o}, 64'h0000_0900);

    // Index and CRC failures together
    run_cmd("idxcrc", 6'd17, 32'h55AA_0000, 2'b01, 3'd0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1,
            16'd0, 0, 1, 0, {2'b00, 6'd18, 32'hDEAD_BEEF}, 16'h0000, 1'b0);
    chk("idxcrc literal err", 64'(bus.err_o), 64'b0110);

    // Timeout after 11 WAIT cycles
    run_cmd("tmo10", 6'd17, 32'h1, 2'b01, 3'd1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0,
            16'd10, 1, -1, 0, 40'd0, 16'd0, 1'b0);
    chk("tmo10 literal err", 64'(bus.err_o), 64'b1000);

    // Timeout disabled: long silence is tolerated
    run_cmd("tmo0", 6'd8, 32'h1AA, 2'b01, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0,
            16'd0, 2, 200, 1, 40'h08_0000_01AA, 16'h0040, 1'b0);

    // No-response command: framing garbage ignored
    run_cmd("cmd0", 6'd0, 32'h0, 2'b00, 3'd2, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1,
            16'd0, 0, 3, 0, 40'hFF_0000_0000, 16'h0000, 1'b0);
    chk("cmd0 literal err", 64'(bus.err_o), 64'd0);

    // Response arriving on the exact timeout edge wins
    run_cmd("race", 6'd17, 32'h2, 2'b01, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0,
            16'd5, 0, 5, 1, 40'h11_1234_5678, 16'h0040, 1'b0);

    // start_i during WAIT is ignored
    run_cmd("poke", 6'd24, 32'hCAFE_F00D, 2'b10, 3'd4, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0,
            16'd0, 1, 4, 0, 40'h3F_0F0F_0F0F, 16'h0000, 1'b1);

    // Asynchronous reset in the middle of REQ
    bus.start_i = 1'b1; bus.cmd_index_i = 6'd9; bus.cmd_arg_i = 32'hFFFF_0000;
    bus.resp_type_i = 2'b10;
    step();
    bus.start_i = 1'b0;
    chk("pre-reset req", {bus.REQ_OUT, bus.busy_o}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset drop", {bus.REQ_OUT, bus.busy_o, bus.done_o, bus.CMD_OUT}, 64'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("after reset idle", {bus.busy_o, bus.done_o, bus.REQ_OUT, bus.ACK_OUT}, 4'd0);

    // Randomized commands against the model
    for (int n = 0; n < 40; n++) begin
      r_idx = 6'($urandom);
      r_rt = 2'($urandom);
      r_tmo = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(1, 12)) : 16'd0;
      r_cmd = {8'($urandom), $urandom};
      if ($urandom_range(0, 1) == 1) r_cmd[37:32] = r_idx;
      if ($urandom_range(0, 1) == 1) r_cmd[39:38] = 2'b00;
      run_cmd("rand", r_idx, $urandom, r_rt, 3'($urandom), 1'($urandom), 1'($urandom),
              2'($urandom), 1'($urandom), 1'($urandom), r_tmo,
              int'($urandom_range(0, 5)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 3)), r_cmd, 16'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_cmd_issue_ctrl.md
# sd_cmd_issue_ctrl

Command-issue controller that sits directly upstream of `sd_cmd_serial_host`. It accepts one SD command from the register/host side and builds the serial host's `SETTING_IN` and `CMD_IN` words. It runs the REQ/ACK handshake on both the issue and completion legs, times out missing responses, and returns the response payload and error flags.

## Interface
Parameters:
- none; all widths fixed.

Ports:
- SD_CLK_IN  in  1  SD command-path clock; all logic on rising edge.
- RST_IN  in  1  reset; asynchronous, active-low.
- start_i  in  1  issue request; sampled only in IDLE.
- cmd_index_i  in  6  command index.
- cmd_arg_i  in  32  command argument.
- resp_type_i  in  2  response type: 00 none, 01 short (48-bit), 10 long (136-bit), 11 reserved (treated as short).
- dly_i  in  3  turnaround delay, copied to SETTING[10:8].
- block_write_i  in  1  copied to SETTING[11].
- block_read_i  in  1  copied to SETTING[12].
- bus_width_i  in  2  copied to SETTING[14:13].
- idx_chk_en_i  in  1  enable response index check.
- crc_chk_en_i  in  1  enable response CRC check.
- timeout_i  in  16  response timeout in clocks; 0 disables.
- busy_o  out  1  high whenever state is not IDLE.
- done_o  out  1  one-cycle completion pulse.
- resp_o  out  32  captured response bits [31:0].
- err_o  out  4  {timeout, crc, index, framing}.
- SETTING_OUT  out  16  to serial host SETTING_IN.
- CMD_OUT  out  40  to serial host CMD_IN.
- REQ_OUT  out  1  to serial host REQ_IN.
- ACK_OUT  out  1  to serial host ACK_IN.
- ser_req_i  in  1  serial host REQ_OUT (completion).
- ser_ack_i  in  1  serial host ACK_OUT (issue accepted).
- ser_cmd_i  in  40  serial host CMD_OUT (received response).
- ser_status_i  in  16  serial host STATUS; bit 6 = CRC valid.

## Operation
- States: IDLE, REQ, WAIT, ACK.
- IDLE, start_i=1:
  - latch all command inputs; clear err_o and resp_o.
  - load CMD_OUT = {2'b01, cmd_index_i, cmd_arg_i}.
  - load SETTING_OUT: [6:0] = 0 (none), 40 (short), 127 (long); [7] = 0; [10:8] = dly_i; [11] = block_write_i; [12] = block_read_i; [14:13] = bus_width_i; [15] = 0.
  - set REQ_OUT=1; go to REQ.
- REQ: hold REQ_OUT, SETTING_OUT and CMD_OUT stable. On ser_ack_i=1: REQ_OUT=0, clear counter, go to WAIT. No timeout in REQ.
- WAIT: counter increments each cycle (16-bit, saturating).
  - ser_req_i=1: capture resp_o = ser_cmd_i[31:0] and evaluate errors; ACK_OUT=1; go to ACK.
  - timeout_i≠0 and counter==timeout_i, with ser_req_i=0: err_o[3]=1, done_o pulse, go to IDLE.
  - ser_req_i and timeout in the same cycle: the response wins, no timeout flag.
- Error evaluation, applied to short response only; none and long set no flags except timeout:
  - framing err_o[0] if ser_cmd_i[39:38] ≠ 2'b00.
  - index err_o[1] if idx_chk_en and ser_cmd_i[37:32] ≠ latched index.
  - crc err_o[2] if crc_chk_en and ser_status_i[6]=0.
- ACK: hold ACK_OUT=1 until ser_req_i samples 0. Then ACK_OUT=0, done_o=1 for one cycle, go to IDLE.
- resp_o and err_o hold until the next accepted start.
- start_i outside IDLE is ignored.

## Timing
- Reset (RST_IN low, async): state IDLE; every output 0 (busy_o, done_o, resp_o, err_o, SETTING_OUT, CMD_OUT, REQ_OUT, ACK_OUT); counter 0.
- Reset mid-command drops REQ_OUT/ACK_OUT immediately, with no done_o.
- All outputs registered.
- Issue: start_i sampled at edge N → REQ_OUT, CMD_OUT, SETTING_OUT valid and busy_o=1 after edge N.
- ser_ack_i sampled at edge M → REQ_OUT=0 after M.
- ser_req_i sampled at edge K → ACK_OUT=1, resp_o and err_o valid after K.
- ser_req_i low sampled at edge L → ACK_OUT=0, done_o=1 after L; busy_o=0 after L.
- Timeout: the WAIT counter is 0 in the first WAIT cycle. The timeout fires at the edge where counter==timeout_i, i.e. timeout_i+1 WAIT cycles after entry.
- New start_i accepted on the first edge at which busy_o=0, which is the same cycle done_o is high.

## Test plan
- Reset: RST_IN low mid-REQ → REQ_OUT, busy_o, CMD_OUT drop to 0 without a clock edge; after release, state is IDLE.
- Short CMD17, arg 0x00001000, dly_i=3, bus_width_i=2:
  - CMD_OUT=0x5100001000 and SETTING_OUT=0x4328.
  - ser_ack_i after 4 cycles → REQ_OUT falls.
  - ser_req_i with ser_cmd_i=0x1100000900, status bit6=1 → resp_o=0x00000900, err_o=0, ACK_OUT held until ser_req_i low, one done_o pulse.
- Index and CRC errors: CMD17 with both checks on; response index field 18 and status bit6=0 → err_o=4'b0110.
- Timeout: resp short, timeout_i=10, ser_req_i never asserted → err_o=4'b1000 and done_o pulse 11 cycles after entering WAIT. With timeout_i=0 the block waits indefinitely.
- No response (CMD0, resp_type 00) → SETTING_OUT[6:0]=0; a completion with ser_cmd_i=0xFF00000000 yields err_o=0.
- Race and ignore cases:
  - ser_req_i rising on the exact timeout edge → response captured, err_o[3]=0.
  - start_i pulsed during WAIT → ignored, CMD_OUT unchanged.
